// File: rtl/bram_port_arb.sv
// rtl/bram_port_arb.sv - round-robin two-requester arbiter for one single-port BRAM with read-tag return.
// Optional statistics counters are enabled by defining BRAM_ARB_STATS_EN.
module bram_port_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic [DATA_W/8-1:0] we0,
  input  logic [DATA_W/8-1:0] we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   din0,
  input  logic [DATA_W-1:0]   din1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic [ADDR_W-1:0]   BRAM_ADDR,
  output logic [DATA_W/8-1:0] BRAM_WE,
  output logic                BRAM_EN,
  output logic [DATA_W-1:0]   BRAM_DIN,
  input  logic [DATA_W-1:0]   BRAM_DOUT,
  output logic                BRAM_RST,
  output logic [31:0]         stat_gnt0,
  output logic [31:0]         stat_gnt1,
  output logic [31:0]         stat_conf
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d;
  logic              prio_q, prio_d;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_id_q;
  logic              granted;
  logic              win_lock;
  logic              rd_push;

  // An owned port grants only its owner, even when the owner is idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (owner_q)
        OWN_R0: gnt0 = req0;
        OWN_R1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  assign granted   = gnt0 | gnt1;
  assign win_lock  = gnt1 ? lock1 : lock0;
  assign BRAM_ADDR = gnt1 ? addr1 : (gnt0 ? addr0 : '0);
  assign BRAM_WE   = gnt1 ? we1   : (gnt0 ? we0   : '0);
  assign BRAM_DIN  = gnt1 ? din1  : (gnt0 ? din0  : '0);
  assign BRAM_EN   = granted;
  assign BRAM_RST  = 1'b0;
  assign rd_push   = granted && (BRAM_WE == '0);

  always_comb begin
    owner_d = owner_q;
    prio_d  = prio_q;
    if (granted) begin
      if (win_lock) begin
        owner_d = gnt1 ? OWN_R1 : OWN_R0;
      end else begin
        owner_d = OWN_NONE;
        prio_d  = ~gnt1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      prio_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      prio_q       <= prio_d;
      tag_vld_q[0] <= rd_push;
      tag_id_q[0]  <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // Tag pipeline depth equals BRAM read latency, so the tail lines up with BRAM_DOUT.
  assign rvalid0 = rst & tag_vld_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
  assign rvalid1 = rst & tag_vld_q[RD_LAT-1] &  tag_id_q[RD_LAT-1];
  assign rdata0  = BRAM_DOUT;
  assign rdata1  = BRAM_DOUT;

`ifdef BRAM_ARB_STATS_EN
  logic [31:0] stat_gnt0_q, stat_gnt1_q, stat_conf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_gnt0_q <= '0;
      stat_gnt1_q <= '0;
      stat_conf_q <= '0;
    end else begin
      if (gnt0 && (stat_gnt0_q != 32'hFFFF_FFFF)) stat_gnt0_q <= stat_gnt0_q + 32'd1;
      if (gnt1 && (stat_gnt1_q != 32'hFFFF_FFFF)) stat_gnt1_q <= stat_gnt1_q + 32'd1;
      if (req0 && req1 && (owner_q == OWN_NONE) && (stat_conf_q != 32'hFFFF_FFFF))
        stat_conf_q <= stat_conf_q + 32'd1;
    end
  end

  assign stat_gnt0 = stat_gnt0_q;
  assign stat_gnt1 = stat_gnt1_q;
  assign stat_conf = stat_conf_q;
`else
  assign stat_gnt0 = 32'h0;
  assign stat_gnt1 = 32'h0;
  assign stat_conf = 32'h0;
`endif

endmodule
